// File: rtl/l2_arbiter.sv
// Shares the unified L2 port between the L1 I-cache (read-only) and the L1 D-cache
// (read/write). It serves one line transaction at a time and breaks ties round-robin.
module l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              l2_mem_read,
  output logic              l2_mem_write,
  output logic [ADDR_W-1:0] l2_mem_address,
  output logic [LINE_W-1:0] l2_mem_wdata,
  input  logic [LINE_W-1:0] l2_mem_rdata,
  input  logic              l2_mem_resp
);

  typedef enum logic [1:0] {S_RESET, S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              op_write_q, op_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              req_icache, req_dcache, busy;

  assign req_icache = i_pmem_read;
  assign req_dcache = d_pmem_read | d_pmem_write;
  assign busy       = (state_q == S_BUSY);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      S_RESET: state_d = S_IDLE;
      S_IDLE: begin
        if (req_icache || req_dcache) begin
          // On a tie, the requester that was not served last time wins.
          grant_d = (req_icache && req_dcache) ? ~last_grant_q : req_dcache;
          if (grant_d) begin
            addr_d     = d_pmem_address;
            wdata_d    = d_pmem_wdata;
            op_write_d = d_pmem_write;
          end else begin
            addr_d     = i_pmem_address;
            op_write_d = 1'b0;
          end
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (l2_mem_resp) begin
          last_grant_d = grant_q;
          state_d      = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESET;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign l2_mem_read    = busy & ~op_write_q;
  assign l2_mem_write   = busy & op_write_q;
  assign l2_mem_address = addr_q;
  assign l2_mem_wdata   = wdata_q;
  assign i_pmem_resp    = busy & l2_mem_resp & ~grant_q;
  assign d_pmem_resp    = busy & l2_mem_resp & grant_q;
  assign i_pmem_rdata   = l2_mem_rdata;
  assign d_pmem_rdata   = l2_mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: lone requests, ties, mid-transaction changes, reset abort.
module tb_l2_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read, d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata, d_pmem_rdata;
  logic         d_pmem_resp;
  logic         l2_mem_read, l2_mem_write;
  logic [31:0]  l2_mem_address;
  logic [255:0] l2_mem_wdata, l2_mem_rdata;
  logic         l2_mem_resp;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] PAT_A = {32{8'hAA}};
  localparam logic [255:0] PAT_5 = {32{8'h55}};
  localparam logic [255:0] PAT_C = {8{32'h1234_5678}};

  l2_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .l2_mem_read(l2_mem_read), .l2_mem_write(l2_mem_write),
    .l2_mem_address(l2_mem_address), .l2_mem_wdata(l2_mem_wdata),
    .l2_mem_rdata(l2_mem_rdata), .l2_mem_resp(l2_mem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".rd"},   {255'd0, l2_mem_read},  256'd0);
    chk({tag, ".wr"},   {255'd0, l2_mem_write}, 256'd0);
    chk({tag, ".iresp"}, {255'd0, i_pmem_resp}, 256'd0);
    chk({tag, ".dresp"}, {255'd0, d_pmem_resp}, 256'd0);
  endtask

  // Called one cycle after the request edge, with the arbiter expected to be in Busy.
  // Holds lat cycles, then gives the L2 response and walks through Done back to Idle.
  task automatic serve(input string tag, input int lat, input logic exp_d, input logic exp_wr,
                       input logic [31:0] exp_addr, input logic [255:0] exp_wdata,
                       input logic [255:0] rd);
    for (int c = 0; c < lat; c++) begin
      chk({tag, ".rd"},   {255'd0, l2_mem_read},  {255'd0, ~exp_wr});
      chk({tag, ".wr"},   {255'd0, l2_mem_write}, {255'd0, exp_wr});
      chk({tag, ".addr"}, {224'd0, l2_mem_address}, {224'd0, exp_addr});
      if (exp_wr) chk({tag, ".wdata"}, l2_mem_wdata, exp_wdata);
      chk({tag, ".iresp_wait"}, {255'd0, i_pmem_resp}, 256'd0);
      chk({tag, ".dresp_wait"}, {255'd0, d_pmem_resp}, 256'd0);
      step();
    end
    l2_mem_resp  = 1'b1;
    l2_mem_rdata = rd;
    #1;
    chk({tag, ".iresp"}, {255'd0, i_pmem_resp}, {255'd0, ~exp_d});
    chk({tag, ".dresp"}, {255'd0, d_pmem_resp}, {255'd0, exp_d});
    chk({tag, ".rdata"}, exp_d ? d_pmem_rdata : i_pmem_rdata, rd);
    step();
    l2_mem_resp = 1'b0;
    #1;
    chk_quiet({tag, ".done"});
    step();
  endtask

  initial begin
    rst = 1'b1;
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    l2_mem_rdata = '0; l2_mem_resp = 0;
    step(); step();
    chk_quiet("reset");
    chk("reset.addr",  {224'd0, l2_mem_address}, 256'd0);
    chk("reset.wdata", l2_mem_wdata, 256'd0);
    rst = 1'b0;
    step();

    // Stray L2 response while idle must be ignored.
    l2_mem_resp = 1'b1;
    #1;
    chk_quiet("stray");
    step();
    l2_mem_resp = 1'b0;

    // Lone I read.
    i_pmem_read = 1; i_pmem_address = 32'h0000_1040;
    #1;
    chk("i_lat0.rd", {255'd0, l2_mem_read}, 256'd0);
    step();
    serve("i_read", 5, 1'b0, 1'b0, 32'h1040, '0, PAT_A);
    i_pmem_read = 0;

    // Lone D write.
    d_pmem_write = 1; d_pmem_address = 32'h2000; d_pmem_wdata = PAT_5;
    step();
    serve("d_write", 3, 1'b1, 1'b1, 32'h2000, PAT_5, '0);
    d_pmem_write = 0;

    // Four back-to-back ties alternate I, D, I, D (last grant was D).
    i_pmem_read = 1; i_pmem_address = 32'h100;
    d_pmem_read = 1; d_pmem_address = 32'h200;
    step();
    serve("tie1_I", 2, 1'b0, 1'b0, 32'h100, '0, PAT_C);
    step();
    serve("tie2_D", 2, 1'b1, 1'b0, 32'h200, '0, PAT_A);
    step();
    serve("tie3_I", 1, 1'b0, 1'b0, 32'h100, '0, PAT_5);
    step();
    serve("tie4_D", 1, 1'b1, 1'b0, 32'h200, '0, PAT_C);
    i_pmem_read = 0; d_pmem_read = 0;

    // D read+write together is a single write.
    d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 32'h400; d_pmem_wdata = PAT_C;
    step();
    serve("d_rw", 3, 1'b1, 1'b1, 32'h400, PAT_C, '0);
    d_pmem_read = 0; d_pmem_write = 0;

    // I address changes mid-Busy; latched address must hold.
    i_pmem_read = 1; i_pmem_address = 32'h300;
    step();
    i_pmem_address = 32'h340;
    serve("i_chg", 4, 1'b0, 1'b0, 32'h300, '0, PAT_A);
    i_pmem_read = 0;

    // Reset in the third Busy cycle of a D read aborts it; next tie goes to I.
    d_pmem_read = 1; d_pmem_address = 32'h500;
    step();
    chk("abort.busy_rd", {255'd0, l2_mem_read}, 256'd1);
    step(); step();
    rst = 1'b1;
    step();
    chk_quiet("abort");
    chk("abort.addr", {224'd0, l2_mem_address}, 256'd0);
    rst = 1'b0;
    step();
    i_pmem_read = 1; i_pmem_address = 32'h600;
    step();
    serve("post_rst_tie", 2, 1'b0, 1'b0, 32'h600, '0, PAT_5);
    i_pmem_read = 0; d_pmem_read = 0;
    step();
    chk_quiet("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
